pwm_multi: RTL

Multi-channel PWM generator and the parametrised successor of the single-channel prescaled PWM. A shared prescaler and a shared period counter drive CHANNELS independent duty comparators. It adds edge-aligned and center-aligned modes, a 100 % duty code, and shadow-buffered duty and mode registers that update glitch-free at the period boundary. It sits between the register/IO wrapper and the pads.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_if.sv | 33 +++
 rtl/pwm_prescaler.sv | 33 +++
 rtl/pwm_multi.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// ============================================================================
// Module : pwm_pkg
// Brief  : Shared types and index helpers for the multi-channel PWM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    // Each channel's duty code is WIDTH+1 bits so that 2^WIDTH can mean 100 %.
    function automatic int unsigned duty_slice(input int unsigned c, input int unsigned width);
        return c * (width + 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_if.sv
// ============================================================================
// Module : pwm_if
// Brief  : Configuration and output bundle between the register wrapper and
//          the PWM core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PSC_W    = 32
);
    logic                              en_i;
    logic [PSC_W-1:0]                  psc_i;
    logic                              center_i;
    logic [CHANNELS*(WIDTH+1)-1:0]     duty_i;
    logic                              duty_we_i;
    logic [CHANNELS-1:0]               pwm_o;
    logic                              period_o;

    modport master (
        output en_i, psc_i, center_i, duty_i, duty_we_i,
        input  pwm_o, period_o
    );

    modport slave (
        input  en_i, psc_i, center_i, duty_i, duty_we_i,
        output pwm_o, period_o
    );
endinterface

`default_nettype wire

// File: rtl/pwm_prescaler.sv
// ============================================================================
// Module : pwm_prescaler
// Brief  : Divides clk by psc_i+1 into a single-cycle tick; frozen while idle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_prescaler #(
    parameter int PSC_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_i,
    input  wire logic             en_i,
    input  wire logic [PSC_W-1:0] psc_i,
    output logic                  tick_o
);

    logic [PSC_W-1:0] q;

    // >= rather than == so a divisor lowered below q wraps at once.
    assign tick_o = en_i && (q >= psc_i);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            q <= '0;
        end else if (en_i) begin
            q <= tick_o ? '0 : q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pwm_multi.sv
// ============================================================================
// Module : pwm_multi
// Brief  : Multi-channel PWM with shared prescaler/counter, edge or center
//          alignment and shadow-buffered duty/mode registers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PSC_W    = 32
) (
    input  wire logic clk,
    input  wire logic rst_i,
    pwm_if.slave      bus
);

    localparam int unsigned      MAX_I    = cnt_max(WIDTH);
    localparam logic [WIDTH-1:0] MAX      = MAX_I[WIDTH-1:0];
    localparam logic [0:0]       DIR_UP   = 1'b0;
    localparam logic [0:0]       DIR_DOWN = 1'b1;

    logic                tick;
    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    cnt_next;
    logic [0:0]          dir;
    logic [0:0]          dir_next;
    logic                boundary;
    logic                load_active;
    pwm_mode_e           pend_mode;
    pwm_mode_e           act_mode;
    logic                period_q;
    logic [CHANNELS-1:0] pwm_vec;

    pwm_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_i  (rst_i),
        .en_i   (bus.en_i),
        .psc_i  (bus.psc_i),
        .tick_o (tick)
    );

    always_comb begin
        cnt_next = cnt;
        dir_next = dir;
        if (act_mode == PWM_EDGE) begin
            cnt_next = cnt + 1'b1;
            dir_next = DIR_UP;
        end else if (dir == DIR_UP) begin
            if (cnt == MAX) begin
                cnt_next = cnt - 1'b1;
                dir_next = DIR_DOWN;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end else begin
            cnt_next = cnt - 1'b1;
        end
        // Every period restarts rising, which also covers a mode switch.
        if (cnt_next == '0) begin
            dir_next = DIR_UP;
        end
    end

    assign boundary    = tick && (cnt_next == '0);
    assign load_active = boundary || !bus.en_i;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt       <= '0;
            dir       <= DIR_UP;
            pend_mode <= PWM_EDGE;
            act_mode  <= PWM_EDGE;
            period_q  <= 1'b0;
        end else begin
            if (tick) begin
                cnt <= cnt_next;
                dir <= dir_next;
            end
            if (bus.duty_we_i) begin
                pend_mode <= bus.center_i ? PWM_CENTER : PWM_EDGE;
            end
            if (load_active) begin
                act_mode <= pend_mode;
            end
            period_q <= boundary;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        localparam int unsigned LSB = duty_slice(c, WIDTH);

        logic [WIDTH:0] pend_duty;
        logic [WIDTH:0] act_duty;
        logic           pwm_q;

        always_ff @(posedge clk) begin
            if (rst_i) begin
                pend_duty <= '0;
                act_duty  <= '0;
                pwm_q     <= 1'b0;
            end else begin
                if (bus.duty_we_i) begin
                    pend_duty <= bus.duty_i[LSB +: WIDTH+1];
                end
                if (load_active) begin
                    act_duty <= pend_duty;
                end
                pwm_q <= bus.en_i && ({1'b0, cnt} < act_duty);
            end
        end

        assign pwm_vec[c] = pwm_q;
    end

    assign bus.pwm_o    = pwm_vec;
    assign bus.period_o = period_q;

endmodule

`default_nettype wire
